// File: rtl/delay_match_fifo.sv
// delay_match_fifo: first-word-fall-through sideband FIFO with a registered head, sticky error flags
// and an optional high-water mark (DELAY_MATCH_FIFO_HWM_EN).
module delay_match_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_full,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
`ifdef DELAY_MATCH_FIFO_HWM_EN
  ,
  output logic [ADDR_WIDTH:0]   o_hwm
`endif
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, wr_n, rd_n, cnt_n;
  logic push_ok, pop_ok;
  always_comb begin
    pop_ok = i_pop && o_valid;
    push_ok = i_push && (!o_full || i_pop);
    wr_n = wr_ptr + (ADDR_WIDTH+1)'(push_ok);
    rd_n = rd_ptr + (ADDR_WIDTH+1)'(pop_ok);
    cnt_n = wr_n - rd_n;
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_data;
  // The head register looks one edge ahead, bypassing a word written into the next head slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
      o_full <= 1'b0;
      o_data <= '0;
      o_overflow <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      o_count <= cnt_n;
      o_valid <= cnt_n != '0;
      o_full <= cnt_n == (ADDR_WIDTH+1)'(DEPTH);
      o_data <= (push_ok && wr_ptr[ADDR_WIDTH-1:0] == rd_n[ADDR_WIDTH-1:0]) ? i_data : mem[rd_n[ADDR_WIDTH-1:0]];
      o_overflow <= o_overflow | (i_push & ~push_ok);
      o_underflow <= o_underflow | (i_pop & ~o_valid);
    end
  end
`ifdef DELAY_MATCH_FIFO_HWM_EN
  always_ff @(posedge clk)
    if (!rst_n) o_hwm <= '0;
    else o_hwm <= (o_count > o_hwm) ? o_count : o_hwm;
`endif
endmodule

// File: tb/tb_delay_match_fifo.sv
// tb_delay_match_fifo: queue-model and directed-vector bench for delay_match_fifo.
module tb_delay_match_fifo;
  localparam int DW = 8, DEPTH = 16, AW = 4;
  logic clk = 1'b0, rst_n = 1'b0, i_push = 1'b0, i_pop = 1'b0;
  logic [DW-1:0] i_data = '0, o_data;
  logic o_valid, o_full, o_overflow, o_underflow;
  logic [AW:0] o_count;
`ifdef DELAY_MATCH_FIFO_HWM_EN
  logic [AW:0] o_hwm;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  delay_match_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_push(i_push), .i_data(i_data), .i_pop(i_pop),
    .o_data(o_data), .o_valid(o_valid), .o_full(o_full), .o_count(o_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
`ifdef DELAY_MATCH_FIFO_HWM_EN
    , .o_hwm(o_hwm)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue plus flags, stepped on each rising edge.
  logic [DW-1:0] q[$];
  bit m_live = 0, m_ovf = 0, m_unf = 0;
  int m_hwm = 0;
  always @(posedge clk) begin
    int sz;
    bit pop_ok, push_ok;
    sz = q.size();
    if (!rst_n) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_hwm = 0;
      m_live = 1;
    end else if (m_live) begin
      m_hwm = (sz > m_hwm) ? sz : m_hwm;
      pop_ok = i_pop && sz > 0;
      push_ok = i_push && (sz < DEPTH || i_pop);
      if (i_pop && !pop_ok) m_unf = 1;
      if (i_push && !push_ok) m_ovf = 1;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(i_data);
    end
  end

  always @(negedge clk) if (m_live) begin
    chk("m_valid", int'(o_valid), int'(q.size() > 0));
    chk("m_count", int'(o_count), q.size());
    chk("m_full", int'(o_full), int'(q.size() == DEPTH));
    chk("m_ovf", int'(o_overflow), int'(m_ovf));
    chk("m_unf", int'(o_underflow), int'(m_unf));
    if (q.size() > 0) chk("m_data", int'(o_data), int'(q[0]));
`ifdef DELAY_MATCH_FIFO_HWM_EN
    chk("m_hwm", int'(o_hwm), m_hwm);
`endif
  end

  task automatic step(input bit p, input bit r, input logic [DW-1:0] d);
    i_push = p;
    i_pop = r;
    i_data = d;
    @(negedge clk);
    i_push = 0;
    i_pop = 0;
  endtask

  logic [DW-1:0] sb[$];
  int pushed, popped, occ, peak;
  bit p, r;
  logic [DW-1:0] d;
  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("t1_valid", int'(o_valid), 0);
    chk("t1_full", int'(o_full), 0);
    chk("t1_count", int'(o_count), 0);
    chk("t1_ovf", int'(o_overflow), 0);
    chk("t1_unf", int'(o_underflow), 0);
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    chk("t2_count3", int'(o_count), 3);
    chk("t2_d0", int'(o_data), 'h11);
    step(0, 1, 0);
    chk("t2_d1", int'(o_data), 'h22);
    step(0, 1, 0);
    chk("t2_d2", int'(o_data), 'h33);
    step(0, 1, 0);
    chk("t2_valid", int'(o_valid), 0);
    chk("t2_count0", int'(o_count), 0);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h80 + i));
    chk("t3_full", int'(o_full), 1);
    chk("t3_count", int'(o_count), 16);
    chk("t3_ovf0", int'(o_overflow), 0);
    step(1, 0, 8'hAA);
    chk("t3_ovf1", int'(o_overflow), 1);
    chk("t3_head", int'(o_data), 'h80);
    step(1, 1, 8'h5A);
    chk("t4_count", int'(o_count), 16);
    chk("t4_head", int'(o_data), 'h81);
    repeat (15) step(0, 1, 0);
    chk("t4_5a", int'(o_data), 'h5A);
    chk("t4_count1", int'(o_count), 1);
    step(0, 1, 0);
    chk("t5_unf0", int'(o_underflow), 0);
    step(1, 1, 8'h7E);
    chk("t5_unf1", int'(o_underflow), 1);
    chk("t5_count", int'(o_count), 1);
    chk("t5_data", int'(o_data), 'h7E);
    step(0, 1, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t6_rst_ovf", int'(o_overflow), 0);
    pushed = 0;
    popped = 0;
    peak = 0;
    while (popped < 40) begin
      occ = pushed - popped;
      r = occ > 0 && $urandom_range(0, 1) == 1;
      p = pushed < 40 && (occ < DEPTH || r) && $urandom_range(0, 2) != 0;
      if (!p && !r) continue;
      d = 8'($urandom);
      if (r) begin
        chk("t6_sb", int'(o_data), int'(sb[0]));
        void'(sb.pop_front());
        popped++;
      end
      if (p) begin
        sb.push_back(d);
        pushed++;
      end
      step(p, r, d);
      occ = pushed - popped;
      if (occ > peak) peak = occ;
    end
    chk("t6_empty", int'(o_valid), 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'(i + 1));
    if (peak < 5) peak = 5;
    step(0, 0, 0);
    chk("t6_occ5", int'(o_count), 5);
`ifdef DELAY_MATCH_FIFO_HWM_EN
    chk("t6_hwm_peak", int'(o_hwm), peak);
`endif
    rst_n = 0;
    @(negedge clk);
    chk("t6_rst_count", int'(o_count), 0);
    chk("t6_rst_valid", int'(o_valid), 0);
`ifdef DELAY_MATCH_FIFO_HWM_EN
    chk("t6_rst_hwm", int'(o_hwm), 0);
`endif
    rst_n = 1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
